// File: rtl/sar_scan_sequencer.sv
// Multi-channel scan scheduler in front of the SAR FSM: walks a latched channel mask,
// settles the mux, pulses sar_start and publishes each tagged result (timeout -> res_err).
module sar_scan_sequencer #(
  parameter int NCH     = 4,
  parameter int WIDTH   = 8,
  parameter int SETTLE  = 3,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   cont,
  input  logic                   trig,
  input  logic [NCH-1:0]         ch_mask,
  output logic [$clog2(NCH)-1:0] mux_sel,
  output logic                   sar_start,
  input  logic                   sar_done,
  input  logic [WIDTH-1:0]       sar_data,
  output logic                   res_valid,
  output logic [$clog2(NCH)-1:0] res_ch,
  output logic [WIDTH-1:0]       res_data,
  output logic                   res_err,
  output logic                   scan_done,
  output logic                   busy
);
  // state  | meaning
  // IDLE   | no scan in flight; waits for en & (trig | cont) & mask != 0
  // SETTLE | mux driven, waiting SETTLE cycles for the analog path to settle
  // START  | single-cycle sar_start pulse
  // WAIT   | waiting for sar_done under the TIMEOUT watchdog
  localparam int SW = $clog2(NCH);
  localparam int CW = $clog2(SETTLE + 1) + 1;
  localparam int TW = $clog2(TIMEOUT + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_START, S_WAIT} state_t;
  localparam state_t ENTRY = (SETTLE == 0) ? S_START : S_SETTLE;

  state_t          state, state_nxt;
  logic [NCH-1:0]  mask_q, mask_d;
  logic [CW-1:0]   settle_cnt, settle_cnt_d;
  logic [TW-1:0]   wait_cnt, wait_cnt_d;
  logic [SW-1:0]   first_ch, nxt_ch, mux_sel_d, res_ch_d;
  logic [WIDTH-1:0] res_data_d;
  logic            nxt_found, start_ok, settle_last, wait_last, adv, go_next;
  logic            sar_start_d, res_valid_d, res_err_d, scan_done_d, busy_d;

  assign start_ok    = en && (trig || cont) && (ch_mask != '0);
  assign settle_last = (int'(settle_cnt) + 1 == SETTLE);
  assign wait_last   = (int'(wait_cnt) + 1 >= TIMEOUT);
  assign adv         = (state == S_WAIT) && (sar_done || wait_last);
  assign go_next     = adv && nxt_found && en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      mask_q     <= '0;
      settle_cnt <= '0;
      wait_cnt   <= '0;
      mux_sel    <= '0;
      sar_start  <= 1'b0;
      res_valid  <= 1'b0;
      res_ch     <= '0;
      res_data   <= '0;
      res_err    <= 1'b0;
      scan_done  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      mask_q     <= mask_d;
      settle_cnt <= settle_cnt_d;
      wait_cnt   <= wait_cnt_d;
      mux_sel    <= mux_sel_d;
      sar_start  <= sar_start_d;
      res_valid  <= res_valid_d;
      res_ch     <= res_ch_d;
      res_data   <= res_data_d;
      res_err    <= res_err_d;
      scan_done  <= scan_done_d;
      busy       <= busy_d;
    end
  end

  // Channel search: descending loops so the lowest qualifying index wins.
  always_comb begin
    first_ch  = '0;
    nxt_ch    = '0;
    nxt_found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ch_mask[i]) first_ch = SW'(i);
      if (mask_q[i] && (i > int'(mux_sel))) begin
        nxt_ch    = SW'(i);
        nxt_found = 1'b1;
      end
    end
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_ok) state_nxt = ENTRY;
      S_SETTLE: if (settle_last) state_nxt = S_START;
      S_START:  state_nxt = S_WAIT;
      S_WAIT:   if (adv) state_nxt = go_next ? ENTRY : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mask_d       = mask_q;
    mux_sel_d    = mux_sel;
    res_ch_d     = res_ch;
    res_data_d   = res_data;
    res_err_d    = res_err;
    res_valid_d  = adv;
    scan_done_d  = adv && !nxt_found && en;
    sar_start_d  = (state_nxt == S_START);
    busy_d       = (state_nxt != S_IDLE);
    settle_cnt_d = (state == S_SETTLE && !settle_last) ? settle_cnt + 1'b1 : '0;
    wait_cnt_d   = (state == S_WAIT && !adv) ? wait_cnt + 1'b1 : '0;
    if (state == S_IDLE && start_ok) begin
      mask_d    = ch_mask;
      mux_sel_d = first_ch;
    end
    if (adv) begin
      res_ch_d   = mux_sel;
      res_data_d = sar_done ? sar_data : '0;
      res_err_d  = !sar_done;
    end
    if (go_next) mux_sel_d = nxt_ch;
  end
endmodule

// File: doc/sar_scan_sequencer.md
Name: sar_scan_sequencer

Overview:
Multi-channel conversion scheduler in front of the SAR binary-search FSM. It walks a latched channel mask in ascending order. For each channel it drives the analog mux select, waits a settle time, pulses the SAR start, and waits for SAR done under a watchdog. Each result is published with its channel tag, and one-shot and continuous scan modes are supported.

Parameters:
NCH, 4, number of mux channels (2..8)
WIDTH, 8, SAR result width
SETTLE, 3, mux settle cycles before start (0 allowed = no settle)
TIMEOUT, 16, max cycles waiting for sar_done before error (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  sequencer enable
cont  in  1  1 = continuous rescan, 0 = single scan per trig
trig  in  1  scan request, sampled in IDLE only
ch_mask  in  NCH  channels to convert, latched at scan start
mux_sel  out  clog2(NCH)  analog mux channel select
sar_start  out  1  one-cycle start pulse to SAR FSM
sar_done  in  1  SAR conversion-complete pulse
sar_data  in  WIDTH  SAR result, valid when sar_done=1
res_valid  out  1  one-cycle result strobe
res_ch  out  clog2(NCH)  channel of current result
res_data  out  WIDTH  result value
res_err  out  1  result produced by timeout
scan_done  out  1  one-cycle strobe, coincident with last res_valid of a scan
busy  out  1  high whenever state != IDLE

Behaviour:
- All outputs are registered. Reset drives state=IDLE and every output to 0.
- States: IDLE, SETTLE, START, WAIT.
- IDLE -> SETTLE when en=1 and (trig=1 or cont=1) and ch_mask!=0. On that edge:
  - latch mask;
  - mux_sel = lowest set bit;
  - settle counter = 0.
- When SETTLE=0, IDLE and advance transitions go directly to START.
- SETTLE holds exactly SETTLE cycles, then goes to START.
- START lasts exactly 1 cycle with sar_start=1, then goes to WAIT. sar_start is 0 in every other state.
- WAIT counts cycles. On the edge sampling sar_done=1, or when the count reaches TIMEOUT, the block advances.
  - Normal advance, next cycle: res_valid=1, res_ch=mux_sel, res_data=sar_data captured on that edge, res_err=0.
  - Timeout advance, next cycle: res_data=0, res_err=1.
- Advance target:
  - next higher set bit exists and en=1: SETTLE/START with mux_sel updated in the same cycle as res_valid;
  - otherwise: IDLE.
- scan_done=1 with the res_valid of the highest masked channel only.
- Transition rule, trig edge = cycle 0: mux_sel is valid from cycle 1, and sar_start is high in cycle SETTLE+1.
- res_ch/res_data/res_err hold their values until the next res_valid. res_valid and scan_done are single-cycle pulses.
- en deasserted mid-scan: the in-flight channel completes (its result and res_valid are issued), then the block returns to IDLE. No scan_done, and the SAR is never abandoned mid-conversion.
- cont=1: after scan_done, the block passes through IDLE for one cycle, relatches ch_mask and restarts if en=1 and mask!=0.
- Ignored inputs:
  - trig while busy=1;
  - trig with ch_mask=0;
  - sar_done outside WAIT.
- ch_mask changes mid-scan have no effect until the next scan start.
- Asynchronous reset mid-operation returns the block to IDLE immediately with outputs 0. The first trig after reset release starts a fresh scan.

Test Plan:
- Bench configuration for all scenarios: NCH=4, WIDTH=8, SETTLE=3, TIMEOUT=16. SAR model raises sar_done 8 cycles after sar_start with data = 0x10 + 0x11*ch.
- Reset asserted/released -> all outputs 0, busy=0. Reset pulse while clk is stopped -> outputs 0 immediately.
- ch_mask=4'b1011, cont=0, 1-cycle trig:
  - sar_start in cycles 4, then in sequence for ch1 and ch3;
  - results (ch0,0x10), (ch1,0x21), (ch3,0x43), all res_err=0;
  - scan_done coincident with ch3; then busy=0.
- ch_mask=4'b0100, SAR model silent -> after 16 WAIT cycles: res_valid, res_ch=2, res_data=0x00, res_err=1, scan_done=1. A late sar_done afterwards is ignored.
- cont=1, ch_mask=4'b0001:
  - repeated ch0 results with scan_done each time, separated by one IDLE cycle;
  - drop en during WAIT -> that result is issued, no scan_done, then IDLE.
- Ignored-input checks, each giving no state change and no output change:
  - trig with mask=0 -> busy stays 0;
  - trig during SETTLE;
  - sar_done pulse during SETTLE;
  - ch_mask change mid-scan -> current scan unaffected.
- rst asserted during WAIT on ch1 -> outputs 0 same cycle; release, trig with mask=4'b0010 -> normal ch1 result 0x21.
